arf_multiport: RTL
==================

# arf_multiport

Parametrised successor to the two-read/one-write architectural register file of the I2OI core. It provides NRD combinational read ports and NWR synchronous write ports, a per-register busy scoreboard for in-order issue, and a reset-time init sequencer that loads each register with its own index. It sits between decode/issue, which read operands and allocate destinations, and writeback, which writes results and clears busy.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers (power of two, ≥2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- AW, $clog2(NREGS), register address width (derived, not overridden)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_addr  in  NRD*AW  packed read addresses; port k at bits [k*AW +: AW]
- rd_data  out  NRD*DATA_W  packed read data
- rd_busy  out  NRD  busy bit of each addressed register
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  packed write addresses
- wr_data  in  NWR*DATA_W  packed write data
- alloc_en  in  1  mark alloc_reg busy (destination issued)
- alloc_reg  in  AW  register being allocated
- init_done  out  1  high once the init sequence has completed

## Operation
- States: INIT and READY. rst_n low: state = INIT, init counter = 0, all busy bits = 0, init_done = 0.
- INIT: each cycle with rst_n high writes memory[cnt] = cnt (zero-extended to DATA_W) and increments cnt. After writing NREGS-1, next state is READY.
- While in INIT, wr_en and alloc_en are ignored, rd_data = 0, and rd_busy = 0.
- READY writes: memory[wr_addr[j]] <= wr_data[j] for each j with wr_en[j]. Each such write clears busy[wr_addr[j]].
- Write conflict (same address on several ports): the highest-index port wins for both data and bypass.
- alloc_en sets busy[alloc_reg]. If the same register is also written that cycle, alloc wins and busy ends at 1.
- Reads are combinational: rd_data[k] = memory[rd_addr[k]] and rd_busy[k] = busy[rd_addr[k]], subject to the bypass rules under Configuration.
- A write to a non-busy register is legal; it updates data and leaves busy = 0.

## Timing
- Read latency 0 cycles. Write and busy updates become visible in storage on the next rising edge.
- Init takes exactly NREGS cycles after rst_n goes high. init_done rises in cycle NREGS+1 (count from the first cycle with rst_n high as cycle 1).
- Reset asserted mid-operation: next edge returns to INIT and clears busy; the full init sequence restarts. Data written before the reset is overwritten by the sequence.
- rd_data and rd_busy are 0 from reset until init_done is high.

## Configuration
- ARF_BYPASS_EN defined:
  - A read whose address matches an active same-cycle write returns that write's wr_data (highest matching port).
  - rd_busy for that address reads 0, unless alloc_en targets the same register that cycle.
- ARF_BYPASS_EN undefined:
  - Reads return stored memory and stored busy only.
  - Same-cycle writes are seen by readers one cycle later.

## Structure
- arf_pkg holds:
  - the state enum (ARF_INIT, ARF_READY)
  - default parameter constants (ARF_DATA_W = 32, ARF_NREGS = 32)
- Sub-module arf_scoreboard owns the NREGS busy bits, the alloc/clear priority and the rd_busy lookup, including the bypass term.
- The top level holds the storage array, the init FSM/counter and the data read muxes.

## Test plan
- Init: release rst_n, read addresses 0..31 after init_done → rd_data equals the address (e.g. reg 17 reads 17). init_done is first high at cycle 33.
- Read during init: rd_addr = 5 at cycle 3 → rd_data = 0, rd_busy = 0. wr_en on reg 5 with data 0xAAAA at cycle 3 → ignored; after init, reg 5 reads 5.
- Write conflict: ports 0 and 1 both write reg 9 with 0x11 and 0x22 → reg 9 reads 0x22 next cycle. With ARF_BYPASS_EN, the same-cycle read also returns 0x22.
- Scoreboard: alloc reg 4 → rd_busy = 1 from the next cycle. Writeback of 0xDEAD to reg 4 → busy clears. Simultaneous alloc and write of reg 4 → busy remains 1 and data = 0xDEAD.
- Bypass off (ARF_BYPASS_EN undefined): write 0x1234 to reg 3 while reading reg 3 → same cycle reads 3, next cycle reads 0x1234.
- Mid-operation reset: write 0xFFFF to reg 2, assert rst_n low for 1 cycle → busy all 0, init_done = 0, and after re-init reg 2 reads 2.

Source files
------------

// File: rtl/arf_pkg.sv
// ============================================================================
// Module   : arf_pkg
// Purpose  : Shared types and default sizes for the multi-port architectural
//            register file (arf_multiport) and its busy scoreboard.
// Contents : arf_state_e - init sequencer states (ARF_INIT, ARF_READY)
//            ARF_DATA_W  - default register width
//            ARF_NREGS   - default register count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arf_pkg;

  localparam int ARF_DATA_W = 32;
  localparam int ARF_NREGS  = 32;

  typedef enum logic [0:0] {
    ARF_INIT  = 1'b0,
    ARF_READY = 1'b1
  } arf_state_e;

endpackage

`default_nettype wire

// File: rtl/arf_scoreboard.sv
// ============================================================================
// Module   : arf_scoreboard
// Purpose  : Per-register busy bits for in-order issue. Allocation sets a
//            bit, writeback clears it, and allocation wins when both target
//            the same register in one cycle. Provides the busy lookup for
//            every read port.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            ready            - high once init is complete; gates updates
//                               and forces rd_busy to 0 while low
//            wr_en, wr_addr   - writeback ports (clear busy)
//            alloc_en/_reg    - destination allocation (set busy)
//            rd_addr, rd_busy - packed read addresses / busy results
// Config   : ARF_BYPASS_EN - a same-cycle write to the addressed register
//            reports not-busy, unless that register is also allocated now.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arf_scoreboard
  import arf_pkg::*;
#(
  parameter  int NREGS = ARF_NREGS,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_reg,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Clears first, set last: allocation overrides a same-cycle writeback.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        w_busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en) begin
      w_busy_nxt[alloc_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (ready) begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
    logic [AW-1:0] w_addr;
    assign w_addr = rd_addr[k*AW +: AW];
`ifdef ARF_BYPASS_EN
    logic w_hit;
    logic w_alloc_same;
    always_comb begin
      w_hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == w_addr)) begin
          w_hit = 1'b1;
        end
      end
    end
    assign w_alloc_same = alloc_en && (alloc_reg == w_addr);
    // A pending writeback hides the stored busy bit unless it is being
    // re-allocated in the same cycle.
    assign rd_busy[k] = ready & r_busy[w_addr] & ~(w_hit & ~w_alloc_same);
`else
    assign rd_busy[k] = ready & r_busy[w_addr];
`endif
  end

endmodule

`default_nettype wire

// File: rtl/arf_multiport.sv
// ============================================================================
// Module   : arf_multiport
// Purpose  : Parametrised architectural register file with NRD combinational
//            read ports, NWR synchronous write ports, a busy scoreboard and
//            a reset-time sequencer that loads every register with its index.
// Ports    : clk, rst_n  - clock, synchronous active-low reset
//            rd_addr     - NRD packed read addresses (port k at [k*AW +: AW])
//            rd_data     - NRD packed read data
//            rd_busy     - busy bit of each addressed register
//            wr_en/addr/data - NWR packed write ports
//            alloc_en/alloc_reg - destination allocation (sets busy)
//            init_done   - high once the init sequence has finished
// Config   : ARF_BYPASS_EN - reads see same-cycle writes (highest port wins)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arf_multiport
  import arf_pkg::*;
#(
  parameter  int DATA_W = ARF_DATA_W,
  parameter  int NREGS  = ARF_NREGS,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_reg,
  output logic                  init_done
);

  logic [DATA_W-1:0] r_mem [NREGS];
  arf_state_e        r_state;
  logic [AW-1:0]     r_cnt;
  logic              r_init_done;
  logic              w_ready;

  assign w_ready   = (r_state == ARF_READY);
  assign init_done = r_init_done;

  // Init sequencer: one register per cycle, then READY after the last index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ARF_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ARF_INIT: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(NREGS - 1)) begin
            r_state     <= ARF_READY;
            r_init_done <= 1'b1;
          end
        end
        ARF_READY: begin
          r_state <= ARF_READY;
        end
        default: begin
          r_state <= ARF_INIT;
        end
      endcase
    end
  end

  // Storage has no reset: the init sequence rewrites every entry anyway.
  // Later ports overwrite earlier ones, so the highest-index port wins.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ARF_INIT) begin
        r_mem[r_cnt] <= DATA_W'(r_cnt);
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j]) begin
            r_mem[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd_data
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_val;
    assign w_addr = rd_addr[k*AW +: AW];
`ifdef ARF_BYPASS_EN
    always_comb begin
      w_val = r_mem[w_addr];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == w_addr)) begin
          w_val = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
`else
    assign w_val = r_mem[w_addr];
`endif
    assign rd_data[k*DATA_W +: DATA_W] = w_ready ? w_val : '0;
  end

  arf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (w_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .alloc_en  (alloc_en),
    .alloc_reg (alloc_reg),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );

endmodule

`default_nettype wire
